// File: rtl/eqv_sweep_ctrl.sv
// rtl/eqv_sweep_ctrl.sv - exhaustive equivalence sweep of a patched circuit against its golden copy
// Walks every input vector, waits for both circuits to settle, and counts output mismatches.
module eqv_sweep_ctrl #(
  parameter int NUM_IN = 3,
  parameter int SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic [NUM_IN-1:0] vec,
  input  logic [1:0]        dut_y,
  input  logic [1:0]        ref_y,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [NUM_IN:0]   mis_cnt,
  output logic [NUM_IN-1:0] fail_vec,
  output logic              fail_valid
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_WAIT,
    S_CHECK,
    S_FIN
  } state_t;

  localparam logic [NUM_IN-1:0] LAST_VEC    = '1;
  localparam logic [3:0]        SETTLE_LAST = 4'(SETTLE - 1);

  state_t              r_state;
  state_t              w_next;
  logic [NUM_IN-1:0]   r_vec;
  logic [3:0]          r_wait;
  logic [NUM_IN:0]     r_mis_cnt;
  logic [NUM_IN-1:0]   r_fail_vec;
  logic                r_fail_valid;
  logic                r_pass;

  logic w_busy;
  logic w_done;
  logic w_begin;
  logic w_step;
  logic w_finish;
  logic w_count;
  logic w_abort;
  logic w_mismatch;

  assign w_mismatch = (dut_y != ref_y);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_busy   = 1'b0;
    w_done   = 1'b0;
    w_begin  = 1'b0;
    w_step   = 1'b0;
    w_finish = 1'b0;
    w_count  = 1'b0;
    w_abort  = 1'b0;
    case (r_state)
      S_IDLE: begin
        // start and abort together is treated as a cancelled request
        if (start && !abort) begin
          w_next  = S_DRIVE;
          w_begin = 1'b1;
        end
      end
      S_DRIVE: begin
        w_busy = 1'b1;
        if (abort) begin
          w_next  = S_IDLE;
          w_abort = 1'b1;
        end else begin
          w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        w_busy = 1'b1;
        if (abort) begin
          w_next  = S_IDLE;
          w_abort = 1'b1;
        end else if (r_wait == SETTLE_LAST) begin
          w_next = S_CHECK;
        end
      end
      S_CHECK: begin
        w_busy = 1'b1;
        if (abort) begin
          w_next  = S_IDLE;
          w_abort = 1'b1;
        end else begin
          w_count = w_mismatch;
          if (r_vec == LAST_VEC) begin
            w_next   = S_FIN;
            w_finish = 1'b1;
          end else begin
            w_next = S_DRIVE;
            w_step = 1'b1;
          end
        end
      end
      S_FIN: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vec        <= '0;
      r_wait       <= '0;
      r_mis_cnt    <= '0;
      r_fail_vec   <= '0;
      r_fail_valid <= 1'b0;
      r_pass       <= 1'b0;
    end else begin
      if (r_state == S_DRIVE)     r_wait <= '0;
      else if (r_state == S_WAIT) r_wait <= r_wait + 4'd1;

      if (w_begin) begin
        r_vec        <= '0;
        r_mis_cnt    <= '0;
        r_fail_valid <= 1'b0;
      end
      if (w_step) r_vec <= r_vec + {{(NUM_IN-1){1'b0}}, 1'b1};

      if (w_count) begin
        r_mis_cnt <= r_mis_cnt + {{NUM_IN{1'b0}}, 1'b1};
        if (!r_fail_valid) begin
          r_fail_vec   <= r_vec;
          r_fail_valid <= 1'b1;
        end
      end

      // the final vector's verdict is folded in here, before mis_cnt updates
      if (w_finish) r_pass <= (r_mis_cnt == '0) && !w_count;
      if (w_abort)  r_pass <= 1'b0;
    end
  end

  assign vec        = r_vec;
  assign busy       = w_busy;
  assign done       = w_done;
  assign pass       = r_pass;
  assign mis_cnt    = r_mis_cnt;
  assign fail_vec   = r_fail_vec;
  assign fail_valid = r_fail_valid;

endmodule
